// File: rtl/spike_input_accumulator.sv
// Spike packet accumulator: pops packets from the input FIFO, sums signed weights per neuron
// with saturation, and drains all neuron currents over valid/ready on each timestep pulse.
module spike_input_accumulator #(
  parameter int DATA_WIDTH  = 12,
  parameter int NEURON_BITS = 4,
  parameter int WEIGHT_BITS = 8,
  parameter int ACC_WIDTH   = 16
) (
  input  logic                         rd_clk,
  input  logic                         rst_n,
  input  logic                         fifo_empty,
  output logic                         fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]        fifo_rd_data,
  input  logic                         timestep,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [NEURON_BITS-1:0]       out_neuron,
  output logic signed [ACC_WIDTH-1:0]  out_current,
  output logic                         out_sat,
  output logic                         busy,
  output logic                         ts_overrun
);

  localparam int NUM_NEURONS = 2 ** NEURON_BITS;
  localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
  localparam logic [NEURON_BITS-1:0] LAST_IDX = NEURON_BITS'(NUM_NEURONS - 1);

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    FLUSH   = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic                         run_q, run_d;
  logic                         pop_q, pop_d;
  logic [NEURON_BITS-1:0]       idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]  acc_q [NUM_NEURONS];
  logic signed [ACC_WIDTH-1:0]  acc_d [NUM_NEURONS];
  logic [NUM_NEURONS-1:0]       sat_q, sat_d;
  logic                         ovr_q, ovr_d;

  logic [NEURON_BITS-1:0]       pkt_neuron;
  logic [WEIGHT_BITS-1:0]       pkt_weight;
  logic [ACC_WIDTH-1:0]         acc_sel;
  logic [ACC_WIDTH:0]           sum;
  logic                         sum_ovf;

  assign pkt_neuron = fifo_rd_data[DATA_WIDTH-1 -: NEURON_BITS];
  assign pkt_weight = fifo_rd_data[WEIGHT_BITS-1:0];

  // run_q holds pops off until the first edge after reset release
  assign fifo_rd_en = run_q && (state_q == COLLECT) && !fifo_empty && !timestep;

  assign out_valid   = (state_q == DRAIN);
  assign busy        = (state_q != COLLECT);
  assign out_neuron  = idx_q;
  assign out_current = acc_q[idx_q];
  assign out_sat     = sat_q[idx_q];
  assign ts_overrun  = ovr_q;

  // Sum one bit wider than the accumulator; a sign mismatch in the top two bits means overflow
  always_comb begin
    acc_sel = acc_q[pkt_neuron];
    sum     = {acc_sel[ACC_WIDTH-1], acc_sel}
            + {{(ACC_WIDTH+1-WEIGHT_BITS){pkt_weight[WEIGHT_BITS-1]}}, pkt_weight};
    sum_ovf = sum[ACC_WIDTH] ^ sum[ACC_WIDTH-1];
  end

  always_comb begin
    state_d = state_q;
    run_d   = 1'b1;
    pop_d   = fifo_rd_en;
    idx_d   = idx_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    ovr_d   = ovr_q | (timestep & busy);

    if (pop_q) begin
      if (sum_ovf) begin
        acc_d[pkt_neuron] = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        sat_d[pkt_neuron] = 1'b1;
      end else begin
        acc_d[pkt_neuron] = sum[ACC_WIDTH-1:0];
      end
    end

    unique case (state_q)
      COLLECT: begin
        if (timestep) state_d = FLUSH;
      end
      FLUSH: begin
        state_d = DRAIN;
        idx_d   = '0;
      end
      DRAIN: begin
        if (out_ready) begin
          acc_d[idx_q] = '0;
          sat_d[idx_q] = 1'b0;
          idx_d        = idx_q + 1'b1;
          if (idx_q == LAST_IDX) state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      run_q   <= 1'b0;
      pop_q   <= 1'b0;
      idx_q   <= '0;
      sat_q   <= '0;
      ovr_q   <= 1'b0;
      for (int i = 0; i < NUM_NEURONS; i++) acc_q[i] <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      pop_q   <= pop_d;
      idx_q   <= idx_d;
      sat_q   <= sat_d;
      ovr_q   <= ovr_d;
      acc_q   <= acc_d;
    end
  end

endmodule

// File: tb/tb_spike_input_accumulator.sv
// Scoreboard bench for spike_input_accumulator: a queue-based FIFO model feeds packets,
// an integer reference model predicts drain words, and a monitor compares every handshake.
module tb_spike_input_accumulator;

  localparam int NN = 16;

  logic              rd_clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              fifo_empty = 1'b1;
  logic              fifo_rd_en;
  logic [11:0]       fifo_rd_data = '0;
  logic              timestep = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [3:0]        out_neuron;
  logic signed [15:0] out_current;
  logic              out_sat;
  logic              busy;
  logic              ts_overrun;

  spike_input_accumulator dut (
    .rd_clk       (rd_clk),
    .rst_n        (rst_n),
    .fifo_empty   (fifo_empty),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_data (fifo_rd_data),
    .timestep     (timestep),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_neuron   (out_neuron),
    .out_current  (out_current),
    .out_sat      (out_sat),
    .busy         (busy),
    .ts_overrun   (ts_overrun)
  );

  always #5 rd_clk = ~rd_clk;

  // FIFO model: requests are sampled mid-cycle, data appears the cycle after a pop
  logic [11:0] fifo_q[$];
  logic        push_req = 1'b0;
  logic [11:0] push_data = '0;
  logic        rd_en_s = 1'b0;
  int          pop_count = 0;

  always @(negedge rd_clk) rd_en_s <= fifo_rd_en;

  always @(posedge rd_clk) begin
    if (rd_en_s && fifo_q.size() > 0) begin
      fifo_rd_data <= fifo_q.pop_front();
      pop_count    <= pop_count + 1;
    end
    if (push_req) fifo_q.push_back(push_data);
    fifo_empty <= (fifo_q.size() == 0);
  end

  typedef struct {
    int neuron;
    int current;
    bit sat;
  } word_t;

  word_t sb_q[$];
  int    exp_cur[NN];
  int    exp_next[NN];
  bit    sat_cur[NN];
  bit    sat_next[NN];
  int    checks = 0;
  int    passes = 0;

  function automatic void checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
  endfunction

  function automatic void model_add(input logic [11:0] pkt, input bit to_next);
    logic [3:0] nb;
    logic signed [7:0] wb;
    int n, s;
    bit sflag;
    nb = pkt[11:8];
    wb = pkt[7:0];
    n = int'(nb);
    s = (to_next ? exp_next[n] : exp_cur[n]) + int'(wb);
    sflag = 1'b0;
    if (s > 32767) begin s = 32767; sflag = 1'b1; end
    else if (s < -32768) begin s = -32768; sflag = 1'b1; end
    if (to_next) begin exp_next[n] = s; sat_next[n] = sat_next[n] | sflag; end
    else begin exp_cur[n] = s; sat_cur[n] = sat_cur[n] | sflag; end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NN; i++) begin
      exp_cur[i] = 0; exp_next[i] = 0; sat_cur[i] = 1'b0; sat_next[i] = 1'b0;
    end
  endfunction

  // Closing a timestep: every neuron is reported in order, then the model rolls over
  function automatic void enqueue_timestep();
    word_t w;
    for (int i = 0; i < NN; i++) begin
      w.neuron = i; w.current = exp_cur[i]; w.sat = sat_cur[i];
      sb_q.push_back(w);
      exp_cur[i] = exp_next[i]; sat_cur[i] = sat_next[i];
      exp_next[i] = 0; sat_next[i] = 1'b0;
    end
  endfunction

  task automatic cycle();
    @(posedge rd_clk);
    #1;
    push_req = 1'b0;
  endtask

  task automatic applyStimulus(input logic [11:0] pkt, input bit to_next);
    cycle();
    push_req  = 1'b1;
    push_data = pkt;
    model_add(pkt, to_next);
  endtask

  task automatic start_timestep();
    cycle();
    timestep = 1'b1;
    enqueue_timestep();
    cycle();
    timestep = 1'b0;
  endtask

  task automatic wait_fifo_empty();
    int n;
    n = 0;
    cycle();
    while (fifo_q.size() != 0 && n < 2000) begin cycle(); n++; end
    if (fifo_q.size() != 0) checkOutput("fifo_drain_timeout", fifo_q.size(), 0);
    repeat (3) cycle();
  endtask

  task automatic wait_drain(input bit random_ready);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 600) begin
      if (random_ready) out_ready = 1'($urandom_range(0, 1));
      cycle();
      n++;
    end
    if (sb_q.size() != 0) checkOutput("drain_timeout", sb_q.size(), 0);
    out_ready = 1'b1;
    repeat (3) cycle();
  endtask

  task automatic check_idle_outputs(input string tag);
    checkOutput({tag, "_fifo_rd_en"}, int'(fifo_rd_en), 0);
    checkOutput({tag, "_out_valid"}, int'(out_valid), 0);
    checkOutput({tag, "_out_neuron"}, int'(out_neuron), 0);
    checkOutput({tag, "_out_current"}, int'(out_current), 0);
    checkOutput({tag, "_out_sat"}, int'(out_sat), 0);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_ts_overrun"}, int'(ts_overrun), 0);
  endtask

  initial begin
    word_t e;
    int    stall_exp, p0, cnt;
    model_clear();

    fork
      forever begin
        @(negedge rd_clk);
        if (rst_n && out_valid && out_ready) begin
          if (sb_q.size() == 0) begin
            checkOutput("unexpected_drain_word", int'(out_neuron), -1);
          end else begin
            e = sb_q.pop_front();
            checkOutput($sformatf("drain_neuron_n%0d", e.neuron), int'(out_neuron), e.neuron);
            checkOutput($sformatf("drain_current_n%0d", e.neuron), int'(out_current), e.current);
            checkOutput($sformatf("drain_sat_n%0d", e.neuron), int'(out_sat), int'(e.sat));
          end
        end
      end
    join_none

    out_ready = 1'b1;
    repeat (3) @(posedge rd_clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (2) cycle();

    $display("[TB] basic accumulate n3 = 5 - 2");
    applyStimulus(12'h305, 1'b0);
    applyStimulus(12'h3FE, 1'b0);
    wait_fifo_empty();
    start_timestep();
    wait_drain(1'b0);
    start_timestep();
    wait_drain(1'b0);

    $display("[TB] positive and negative saturation on n1");
    for (int i = 0; i < 300; i++) applyStimulus(12'h17F, 1'b0);
    wait_fifo_empty();
    start_timestep();
    wait_drain(1'b0);
    for (int i = 0; i < 300; i++) applyStimulus(12'h180, 1'b0);
    wait_fifo_empty();
    start_timestep();
    wait_drain(1'b0);

    $display("[TB] back-pressure at idx 7");
    applyStimulus(12'h70A, 1'b0);
    applyStimulus(12'h833, 1'b0);
    applyStimulus(12'h7F1, 1'b0);
    wait_fifo_empty();
    stall_exp = exp_cur[7];
    start_timestep();
    checkOutput("flush_busy", int'(busy), 1);
    checkOutput("flush_out_valid", int'(out_valid), 0);
    cycle();
    checkOutput("first_valid", int'(out_valid), 1);
    checkOutput("first_neuron", int'(out_neuron), 0);
    for (int i = 0; i < 7; i++) applyStimulus(12'(($urandom_range(0, 15) << 8) | $urandom_range(0, 255)), 1'b0);
    out_ready = 1'b0;
    p0 = pop_count;
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("stall_valid", int'(out_valid), 1);
      checkOutput("stall_neuron", int'(out_neuron), 7);
      checkOutput("stall_current", int'(out_current), stall_exp);
      checkOutput("stall_rd_en", int'(fifo_rd_en), 0);
    end
    checkOutput("stall_pop_count", pop_count, p0);
    out_ready = 1'b1;
    wait_drain(1'b0);
    wait_fifo_empty();

    $display("[TB] timestep during drain");
    checkOutput("overrun_clear_before", int'(ts_overrun), 0);
    applyStimulus(12'hC40, 1'b0);
    wait_fifo_empty();
    start_timestep();
    repeat (4) cycle();
    timestep = 1'b1;
    cycle();
    timestep = 1'b0;
    checkOutput("overrun_set", int'(ts_overrun), 1);
    wait_drain(1'b0);
    repeat (40) cycle();
    checkOutput("no_second_drain_busy", int'(busy), 0);
    checkOutput("overrun_sticky", int'(ts_overrun), 1);

    $display("[TB] packet in flight at timestep");
    applyStimulus(12'h204, 1'b0);
    applyStimulus(12'h206, 1'b1);
    cycle();
    timestep = 1'b1;
    enqueue_timestep();
    cycle();
    timestep = 1'b0;
    wait_drain(1'b0);
    wait_fifo_empty();
    start_timestep();
    wait_drain(1'b0);

    $display("[TB] randomized timesteps");
    for (int r = 0; r < 6; r++) begin
      cnt = $urandom_range(0, 40);
      for (int i = 0; i < cnt; i++) applyStimulus(12'($urandom_range(0, 4095)), 1'b0);
      wait_fifo_empty();
      start_timestep();
      wait_drain(1'b1);
    end

    $display("[TB] reset during drain at idx 5");
    applyStimulus(12'h509, 1'b0);
    applyStimulus(12'h50F, 1'b0);
    applyStimulus(12'hA7F, 1'b0);
    wait_fifo_empty();
    start_timestep();
    repeat (6) cycle();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid_reset");
    sb_q.delete();
    model_clear();
    repeat (2) cycle();
    rst_n = 1'b1;
    repeat (2) cycle();
    start_timestep();
    wait_drain(1'b0);

    checkOutput("scoreboard_empty", sb_q.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/spike_input_accumulator.md
# spike_input_accumulator

Downstream consumer of the core's spike-packet input FIFO, running in the `rd_clk` domain.
- Pops 12-bit spike packets from the FIFO's read port.
- Decodes each packet into a destination neuron index and a signed synaptic weight.
- Accumulates the weight into a per-neuron input-current register with saturation.
- On each `timestep` pulse, drains all accumulated currents in order to the neuron update unit over a valid/ready handshake, then clears them.

## Interface
- `DATA_WIDTH`, 12, packet width; must equal `NEURON_BITS + WEIGHT_BITS`
- `NEURON_BITS`, 4, destination index width; `NUM_NEURONS = 2**NEURON_BITS`
- `WEIGHT_BITS`, 8, signed two's-complement weight width
- `ACC_WIDTH`, 16, signed accumulator width

Ports (reset `rst_n` is asynchronous, active-low; clock is `rd_clk`):
- `rd_clk`  in  1  block clock (FIFO read clock)
- `rst_n`  in  1  asynchronous active-low reset
- `fifo_empty`  in  1  FIFO empty flag
- `fifo_rd_en`  out  1  FIFO pop request
- `fifo_rd_data`  in  DATA_WIDTH  packet; `[11:8]` = neuron, `[7:0]` = weight
- `timestep`  in  1  single-cycle pulse that ends the current timestep
- `out_valid`  out  1  drain word valid
- `out_ready`  in  1  neuron unit accepts the drain word
- `out_neuron`  out  NEURON_BITS  neuron index of the drain word
- `out_current`  out  ACC_WIDTH  signed accumulated current
- `out_sat`  out  1  this neuron's accumulator saturated during the timestep
- `busy`  out  1  high in FLUSH or DRAIN
- `ts_overrun`  out  1  sticky; a `timestep` pulse arrived while `busy`

## Operation
- FIFO contract: `fifo_rd_data` is valid the cycle after a cycle with `fifo_rd_en`=1.
- The block registers `pop_q <= fifo_rd_en`.
- State COLLECT (reset state):
  - `fifo_rd_en = !fifo_empty`; back-to-back pops are allowed every cycle.
  - When `pop_q`=1: `acc[n] <= sat(acc[n] + sext(w))`, with n = `fifo_rd_data[11:8]` and w = `fifo_rd_data[7:0]`.
  - Accumulation is combinational read plus registered write. Consecutive packets to the same neuron therefore accumulate correctly with no stall.
- Saturation:
  - Sum is computed at `ACC_WIDTH+1` bits and clamped to [-32768, 32767].
  - Clamping sets `sat[n]`.
- `timestep`=1 in COLLECT: next state FLUSH.
  - `fifo_rd_en` is forced 0 from that same cycle.
- FLUSH (1 cycle): absorbs the in-flight packet if `pop_q`=1, then goes to DRAIN with `idx`=0.
- DRAIN:
  - `out_valid`=1, `out_neuron`=`idx`, `out_current`=`acc[idx]`, `out_sat`=`sat[idx]`.
  - On `out_valid && out_ready`: `acc[idx]` <= 0, `sat[idx]` <= 0, `idx`++.
  - After `idx`=`NUM_NEURONS-1` is accepted: back to COLLECT.
  - `idx` wraps to 0.
- `fifo_rd_en`=0 in FLUSH and DRAIN. Packets arriving during drain stay in the FIFO and count toward the next timestep.
- `timestep` while `busy`=1: ignored, and `ts_overrun` is set. It is cleared only by reset.
- `timestep` and a pop in the same COLLECT cycle: the pop is not issued. A packet already in flight (`pop_q`) is accumulated into the closing timestep.
- Reset mid-operation:
  - All accumulators and sat bits return to 0, state to COLLECT, `idx` to 0.
  - In-flight data is discarded.

## Timing
- Reset values: `fifo_rd_en`=0, `out_valid`=0, `out_neuron`=0, `out_current`=0, `out_sat`=0, `busy`=0, `ts_overrun`=0.
- Pop to accumulator update: 2 edges (rd_en edge, then accumulate edge). A drain started afterwards reflects the update.
- `timestep` to first `out_valid`: 2 cycles (FLUSH, then DRAIN).
- Drain with `out_ready` held high: `NUM_NEURONS` cycles. COLLECT resumes on the cycle after the last handshake.
- `out_*` are registered/stable while `out_valid`=1 and `out_ready`=0.
- Sustained input throughput in COLLECT: 1 packet per cycle.

## Test plan
- Reset, then push 0x305 (n3, +5) and 0x3FE (n3, -2), then `timestep`.
  - Drain emits n0..n15 with n3 = 3 and all others 0, `out_sat`=0.
  - Accumulators all read 0 on the next drain.
- Push 0x17F (n1, +127) back-to-back 300 times, then `timestep`.
  - n1 = 32767, `out_sat`=1.
  - Repeat with 0x180 (n1, -128) 300 times: n1 = -32768.
- Hold `out_ready`=0 for 5 cycles mid-drain at `idx`=7.
  - `out_neuron`=7 and `out_current` stable throughout.
  - No FIFO pops occur.
  - Resumes at 8 after `out_ready`=1.
- Pulse `timestep` during DRAIN.
  - `ts_overrun`=1; drain completes normally with no second drain.
- Assert `timestep` in the same cycle a packet (n2, +4) is in flight, with FIFO holding (n2, +6).
  - Current drain reports n2 = 4.
  - Next timestep reports n2 = 6.
- Assert `rst_n`=0 at `idx`=5 of a drain.
  - All outputs 0 immediately.
  - After release, a `timestep` with no packets drains 16 zeros.
